// File: rtl/retire_stage.sv
// Retire stage: in-order commit of up to N completed ROB head entries per cycle.
// Handles architectural map updates, free-list returns, mispredict redirects and
// program halt.
//
// head_entries packs N slots, slot i at [i*ENTRY_W +: ENTRY_W]. The bit layout of
// one slot, LSB first:
//   complete | has_dest | dest_arch[ARCH_W] | dest_phys[PHYS_W] | old_phys[PHYS_W]
//   | is_branch | mispredict | target_pc[ADDR_W] | halt
`ifndef N
`define N 3
`endif

module retire_stage #(
  parameter int unsigned N      = `N,
  parameter int unsigned CNT_W  = 64,
  parameter int unsigned ROB_SZ = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned ARCH_W = 5,
  parameter int unsigned PHYS_W = 6,
  localparam int unsigned IDX_W   = $clog2(ROB_SZ),
  localparam int unsigned CW      = $clog2(N + 1),
  localparam int unsigned ENTRY_W = 5 + ARCH_W + 2 * PHYS_W + ADDR_W
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [N*ENTRY_W-1:0]    head_entries,
  input  logic [N-1:0]            head_valids,
  input  logic [IDX_W-1:0]        head_idx,
  output logic [CW-1:0]           retire_count,
  output logic                    mispredict,
  output logic [IDX_W-1:0]        mispred_idx,
  output logic [ADDR_W-1:0]       redirect_pc,
  output logic [N-1:0]            free_valid,
  output logic [N*PHYS_W-1:0]     free_pregs,
  output logic [N-1:0]            amap_we,
  output logic [N*ARCH_W-1:0]     amap_idx,
  output logic [N*PHYS_W-1:0]     amap_preg,
  output logic                    halted,
  output logic [CNT_W-1:0]        retired_total
);

  localparam int unsigned OFF_COMPLETE  = 0;
  localparam int unsigned OFF_HAS_DEST  = 1;
  localparam int unsigned OFF_DEST_ARCH = 2;
  localparam int unsigned OFF_DEST_PHYS = OFF_DEST_ARCH + ARCH_W;
  localparam int unsigned OFF_OLD_PHYS  = OFF_DEST_PHYS + PHYS_W;
  localparam int unsigned OFF_IS_BRANCH = OFF_OLD_PHYS + PHYS_W;
  localparam int unsigned OFF_MISPRED   = OFF_IS_BRANCH + 1;
  localparam int unsigned OFF_TARGET    = OFF_MISPRED + 1;
  localparam int unsigned OFF_HALT      = OFF_TARGET + ADDR_W;

  typedef enum logic [1:0] {RUN, FLUSH, HALT} state_t;

  state_t               state;
  logic                 halt_hit;
  logic                 blocked;
  logic [ENTRY_W-1:0]   entry;
  int                   idx_sum;

  // Retiring-prefix selection and per-slot commit outputs; silent outside RUN or in reset.
  always_comb begin
    retire_count = '0;
    mispredict   = 1'b0;
    mispred_idx  = '0;
    redirect_pc  = '0;
    free_valid   = '0;
    free_pregs   = '0;
    amap_we      = '0;
    amap_idx     = '0;
    amap_preg    = '0;
    halt_hit     = 1'b0;
    blocked      = 1'b0;
    entry        = '0;
    idx_sum      = 0;
    if (!reset && state == RUN) begin
      for (int i = 0; i < int'(N); i++) begin
        entry = head_entries[i*ENTRY_W +: ENTRY_W];
        if (!blocked && head_valids[i] && entry[OFF_COMPLETE]) begin
          retire_count = CW'(i + 1);
          if (entry[OFF_HAS_DEST] && entry[OFF_DEST_ARCH +: ARCH_W] != '0) begin
            amap_we[i]                    = 1'b1;
            amap_idx[i*ARCH_W +: ARCH_W]  = entry[OFF_DEST_ARCH +: ARCH_W];
            amap_preg[i*PHYS_W +: PHYS_W] = entry[OFF_DEST_PHYS +: PHYS_W];
            free_valid[i]                 = 1'b1;
            free_pregs[i*PHYS_W +: PHYS_W] = entry[OFF_OLD_PHYS +: PHYS_W];
          end
          if (entry[OFF_IS_BRANCH] && entry[OFF_MISPRED]) begin
            mispredict  = 1'b1;
            idx_sum     = int'(head_idx) + i;
            mispred_idx = IDX_W'(idx_sum % int'(ROB_SZ));
            redirect_pc = entry[OFF_TARGET +: ADDR_W];
            blocked     = 1'b1;
          end
          if (entry[OFF_HALT]) begin
            halt_hit = 1'b1;
            blocked  = 1'b1;
          end
        end else begin
          blocked = 1'b1;
        end
      end
    end
  end

  // Control FSM, sticky halt flag and retired-instruction counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= RUN;
      halted        <= 1'b0;
      retired_total <= '0;
    end else begin
      retired_total <= retired_total + CNT_W'(retire_count);
      case (state)
        RUN: begin
          if (halt_hit) begin
            state  <= HALT;
            halted <= 1'b1;
          end else if (mispredict) begin
            state <= FLUSH;
          end
        end
        FLUSH:   state <= RUN;
        HALT:    state <= HALT;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_retire_stage.sv
// Self-checking bench for retire_stage: directed scenarios with literal
// expectations followed by randomized traffic against a behavioural model.
module tb_retire_stage;

  localparam int unsigned N      = 3;
  localparam int unsigned CNT_W  = 64;
  localparam int unsigned ROB_SZ = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned ARCH_W = 5;
  localparam int unsigned PHYS_W = 6;
  localparam int unsigned IDX_W  = 5;
  localparam int unsigned CW     = 2;
  localparam int unsigned EW     = 5 + ARCH_W + 2 * PHYS_W + ADDR_W;

  typedef struct {
    bit          complete;
    bit          has_dest;
    int unsigned dest_arch;
    int unsigned dest_phys;
    int unsigned old_phys;
    bit          is_branch;
    bit          mis;
    int unsigned target;
    bit          halt;
  } slot_t;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [N*EW-1:0]      head_entries;
  logic [N-1:0]         head_valids;
  logic [IDX_W-1:0]     head_idx;
  logic [CW-1:0]        retire_count;
  logic                 mispredict;
  logic [IDX_W-1:0]     mispred_idx;
  logic [ADDR_W-1:0]    redirect_pc;
  logic [N-1:0]         free_valid;
  logic [N*PHYS_W-1:0]  free_pregs;
  logic [N-1:0]         amap_we;
  logic [N*ARCH_W-1:0]  amap_idx;
  logic [N*PHYS_W-1:0]  amap_preg;
  logic                 halted;
  logic [CNT_W-1:0]     retired_total;

  retire_stage #(
    .N(N), .CNT_W(CNT_W), .ROB_SZ(ROB_SZ), .ADDR_W(ADDR_W),
    .ARCH_W(ARCH_W), .PHYS_W(PHYS_W)
  ) dut (
    .clock(clk), .reset(reset), .head_entries(head_entries),
    .head_valids(head_valids), .head_idx(head_idx),
    .retire_count(retire_count), .mispredict(mispredict),
    .mispred_idx(mispred_idx), .redirect_pc(redirect_pc),
    .free_valid(free_valid), .free_pregs(free_pregs),
    .amap_we(amap_we), .amap_idx(amap_idx), .amap_preg(amap_preg),
    .halted(halted), .retired_total(retired_total)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  slot_t slot [N];
  slot_t drv  [N];

  // model state: what the block must remember across edges
  bit          m_known = 0;
  bit          m_halt  = 0;
  bit          m_flush = 0;
  logic [63:0] m_total = '0;
  int          e_cnt   = 0;
  bit          e_mis   = 0;
  bit          e_halt  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  function automatic logic [EW-1:0] pack(input slot_t s);
    logic [EW-1:0] e;
    e = '0;
    e[0] = s.complete;
    e[1] = s.has_dest;
    e[2 +: ARCH_W] = ARCH_W'(s.dest_arch);
    e[2+ARCH_W +: PHYS_W] = PHYS_W'(s.dest_phys);
    e[2+ARCH_W+PHYS_W +: PHYS_W] = PHYS_W'(s.old_phys);
    e[2+ARCH_W+2*PHYS_W] = s.is_branch;
    e[3+ARCH_W+2*PHYS_W] = s.mis;
    e[4+ARCH_W+2*PHYS_W +: ADDR_W] = ADDR_W'(s.target);
    e[4+ARCH_W+2*PHYS_W+ADDR_W] = s.halt;
    return e;
  endfunction

  task automatic set_slot(input int i, input bit c, input bit hd, input int unsigned a,
                          input int unsigned p, input int unsigned o, input bit br,
                          input bit ms, input int unsigned t, input bit h);
    slot[i].complete = c;  slot[i].has_dest = hd; slot[i].dest_arch = a;
    slot[i].dest_phys = p; slot[i].old_phys = o;  slot[i].is_branch = br;
    slot[i].mis = ms;      slot[i].target = t;    slot[i].halt = h;
  endtask

  // one cycle: drive just after the edge, return at the following negedge
  task automatic step(input bit rst, input logic [N-1:0] v, input int unsigned idx);
    @(posedge clk);
    #1;
    reset       = rst;
    head_valids = v;
    head_idx    = IDX_W'(idx);
    for (int i = 0; i < int'(N); i++) begin
      drv[i] = slot[i];
      head_entries[i*EW +: EW] = pack(slot[i]);
    end
    @(negedge clk);
  endtask

  // model update at the active edge
  always @(posedge clk) begin
    if (reset) begin
      m_known = 1; m_halt = 0; m_flush = 0; m_total = '0;
    end else if (m_known) begin
      m_total = m_total + 64'(e_cnt);
      m_flush = e_mis;
      if (e_halt) m_halt = 1;
    end
  end

  // compare process: expected outputs from the retirement rules, checked every cycle
  always @(negedge clk) begin
    int len;
    logic [N-1:0]        x_fv, x_we;
    logic [N*PHYS_W-1:0] x_fp, x_ap, pmask;
    logic [N*ARCH_W-1:0] x_ai, amask;
    len = 0;
    if (!(reset || m_halt || m_flush)) begin
      while (len < int'(N) && head_valids[len] === 1'b1 && drv[len].complete) len++;
      for (int k = 0; k < len; k++)
        if ((drv[k].is_branch && drv[k].mis) || drv[k].halt) begin
          len = k + 1;
          break;
        end
    end
    e_cnt  = len;
    e_mis  = len > 0 && drv[len-1].is_branch && drv[len-1].mis;
    e_halt = len > 0 && drv[len-1].halt;
    x_fv = '0; x_we = '0; x_fp = '0; x_ap = '0; x_ai = '0; pmask = '0; amask = '0;
    for (int k = 0; k < len; k++)
      if (drv[k].has_dest && drv[k].dest_arch != 0) begin
        x_fv[k] = 1'b1;
        x_we[k] = 1'b1;
        x_fp[k*PHYS_W +: PHYS_W] = PHYS_W'(drv[k].old_phys);
        x_ap[k*PHYS_W +: PHYS_W] = PHYS_W'(drv[k].dest_phys);
        x_ai[k*ARCH_W +: ARCH_W] = ARCH_W'(drv[k].dest_arch);
        pmask[k*PHYS_W +: PHYS_W] = '1;
        amask[k*ARCH_W +: ARCH_W] = '1;
      end
    chk("m_retire_count", 64'(retire_count), 64'(e_cnt));
    chk("m_mispredict", 64'(mispredict), 64'(e_mis));
    if (e_mis) begin
      chk("m_mispred_idx", 64'(mispred_idx), 64'((head_idx + len - 1) % ROB_SZ));
      chk("m_redirect_pc", 64'(redirect_pc), 64'(drv[len-1].target));
    end
    chk("m_free_valid", 64'(free_valid), 64'(x_fv));
    chk("m_amap_we", 64'(amap_we), 64'(x_we));
    chk("m_free_pregs", 64'(free_pregs & pmask), 64'(x_fp));
    chk("m_amap_preg", 64'(amap_preg & pmask), 64'(x_ap));
    chk("m_amap_idx", 64'(amap_idx & amask), 64'(x_ai));
    if (m_known) begin
      chk("m_halted", 64'(halted), 64'(m_halt));
      chk("m_retired_total", retired_total, m_total);
    end
  end

  initial begin
    logic [N-1:0] v;
    bit rst;
    reset = 1'b1; head_valids = '0; head_idx = '0; head_entries = '0;
    for (int i = 0; i < int'(N); i++) begin
      set_slot(i, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      drv[i] = slot[i];
    end
    step(1, 3'b000, 0);
    step(1, 3'b000, 0);
    chk("rst_count", 64'(retire_count), 0);
    chk("rst_halted", 64'(halted), 0);
    chk("rst_total", retired_total, 0);

    // full-width retire, dest_arch 0 suppresses the last slot's writes
    set_slot(0, 1, 1, 5, 10, 20, 0, 0, 0, 0);
    set_slot(1, 1, 1, 6, 11, 21, 0, 0, 0, 0);
    set_slot(2, 1, 1, 0, 12, 22, 0, 0, 0, 0);
    step(0, 3'b111, 0);
    chk("full_count", 64'(retire_count), 3);
    chk("full_amap_we", 64'(amap_we), 64'(3'b011));
    chk("full_free_valid", 64'(free_valid), 64'(3'b011));
    chk("full_amap_idx0", 64'(amap_idx[4:0]), 5);
    chk("full_free_preg1", 64'(free_pregs[11:6]), 21);

    // empty head window
    step(0, 3'b000, 4);
    chk("full_total", retired_total, 3);
    chk("empty_count", 64'(retire_count), 0);
    chk("empty_amap_we", 64'(amap_we), 0);
    chk("empty_free_valid", 64'(free_valid), 0);
    step(0, 3'b000, 4);
    chk("empty_total", retired_total, 3);

    // incomplete slot 1 blocks slot 2
    set_slot(1, 0, 1, 6, 11, 21, 0, 0, 0, 0);
    step(0, 3'b111, 3);
    chk("gap_count", 64'(retire_count), 1);
    set_slot(1, 1, 1, 6, 11, 21, 0, 0, 0, 0);
    step(0, 3'b111, 4);
    chk("gap_total", retired_total, 4);
    chk("gap_next_count", 64'(retire_count), 3);

    // mispredict at slot 1 with head index wrapping
    set_slot(1, 1, 0, 0, 0, 0, 1, 1, 32'h100, 0);
    step(0, 3'b111, ROB_SZ - 1);
    chk("mis_count", 64'(retire_count), 2);
    chk("mis_flag", 64'(mispredict), 1);
    chk("mis_idx", 64'(mispred_idx), 0);
    chk("mis_pc", 64'(redirect_pc), 64'h100);
    set_slot(1, 1, 1, 6, 11, 21, 0, 0, 0, 0);
    step(0, 3'b111, 1);
    chk("flush_count", 64'(retire_count), 0);
    chk("flush_mis", 64'(mispredict), 0);
    step(0, 3'b111, 1);
    chk("after_flush_count", 64'(retire_count), 3);

    // halt at slot 0
    set_slot(0, 1, 1, 5, 10, 20, 0, 0, 0, 1);
    step(0, 3'b111, 5);
    chk("halt_count", 64'(retire_count), 1);
    set_slot(0, 1, 1, 5, 10, 20, 0, 0, 0, 0);
    step(0, 3'b111, 6);
    chk("halt_flag", 64'(halted), 1);
    chk("halt_count_held", 64'(retire_count), 0);
    step(0, 3'b111, 7);
    chk("halt_count_held2", 64'(retire_count), 0);

    // reset out of HALT
    step(1, 3'b111, 0);
    chk("rst_halt_count", 64'(retire_count), 0);
    chk("rst_halt_we", 64'(amap_we), 0);
    step(0, 3'b111, 0);
    chk("rst_halt_halted", 64'(halted), 0);
    chk("rst_halt_total", retired_total, 0);
    chk("rst_halt_run", 64'(retire_count), 3);

    // reset during FLUSH
    set_slot(0, 1, 0, 0, 0, 0, 1, 1, 32'h40, 0);
    step(0, 3'b111, 0);
    chk("mis0_count", 64'(retire_count), 1);
    set_slot(0, 1, 1, 5, 10, 20, 0, 0, 0, 0);
    step(1, 3'b111, 0);
    chk("rst_flush_count", 64'(retire_count), 0);
    chk("rst_flush_mis", 64'(mispredict), 0);
    step(0, 3'b111, 0);
    chk("rst_flush_run", 64'(retire_count), 3);
    chk("rst_flush_total", retired_total, 0);

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < int'(N); i++) begin
        bit br, h;
        br = ($urandom % 5) == 0;
        h  = !br && ($urandom % 40) == 0;
        set_slot(i, ($urandom % 10) < 8, ($urandom % 10) < 7,
                 (($urandom % 8) == 0) ? 0 : $urandom_range(0, 31),
                 $urandom_range(0, 63), $urandom_range(0, 63),
                 br, br && $urandom_range(0, 1) == 1, $urandom, h);
      end
      for (int i = 0; i < int'(N); i++) v[i] = ($urandom % 100) < 85;
      rst = m_halt ? (($urandom % 8) == 0) : (($urandom % 50) == 0);
      step(rst, v, $urandom_range(0, ROB_SZ - 1));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/retire_stage.md
RETIRE_STAGE -- requirements
Module: retire_stage

Interface
REQ-001 Parameter N, default `N, retire width; must match the ROB head window.
REQ-002 Parameter CNT_W, default 64, width of the retired-instruction counter.
REQ-003 clock  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 head_entries  in  N x ROB_ENTRY  ROB head window, slot 0 = oldest; fields used: complete, has_dest, dest_arch, dest_phys, old_phys, is_branch, mispredict, target_pc, halt.
REQ-006 head_valids  in  N  per-slot occupancy of head_entries.
REQ-007 head_idx  in  ROB_IDX  ROB index of head_entries[0].
REQ-008 retire_count  out  $clog2(N+1)  entries popped by the ROB at the next edge.
REQ-009 mispredict  out  1  flush request to ROB and front end.
REQ-010 mispred_idx  out  ROB_IDX  ROB index of the retiring mispredicted branch.
REQ-011 redirect_pc  out  ADDR  fetch redirect target, valid with mispredict.
REQ-012 free_valid / free_pregs  out  N / N x PHYS_TAG  old physical tags returned to the free list.
REQ-013 amap_we / amap_idx / amap_preg  out  N / N x ARCH_TAG / N x PHYS_TAG  architectural map writes.
REQ-014 halted  out  1  sticky; program has halted.
REQ-015 retired_total  out  CNT_W  running count of retired instructions.

Function
REQ-016 The FSM SHALL have states RUN, FLUSH and HALT; it enters RUN on reset.
REQ-017 In RUN, slot i SHALL retire iff head_valids[0..i] are all 1, every slot 0..i has complete=1, and no slot below i is a mispredicted branch or a halt.
REQ-018 Retirement SHALL be in order: retire_count equals the length of the retiring prefix, 0..N.
REQ-019 retire_count, free_*, amap_*, mispredict, mispred_idx and redirect_pc SHALL be combinational from the current inputs and state, with 0-cycle latency.
REQ-020 For each retiring slot with has_dest=1 and dest_arch!=0: amap_we[i]=1, amap_idx[i]=dest_arch, amap_preg[i]=dest_phys, free_valid[i]=1, free_pregs[i]=old_phys. Otherwise both enables for that slot are 0.
REQ-021 A retiring slot with is_branch=1 and mispredict=1 SHALL itself retire; later slots SHALL NOT retire.
REQ-022 In that cycle the block SHALL drive mispredict=1, mispred_idx=head_idx+slot (mod ROB_SZ, wrap-around) and redirect_pc=target_pc. Next state is FLUSH.
REQ-023 FLUSH SHALL last exactly one cycle with retire_count=0, mispredict=0 and all enables 0. It then returns to RUN.
REQ-024 A retiring slot with halt=1 SHALL retire, block all later slots, and move the FSM to HALT.
REQ-025 In HALT: halted=1, retire_count=0 and all enables 0 until reset.
REQ-026 A mispredict and a halt SHALL never retire in the same cycle, because the older one blocks the younger.
REQ-027 retired_total SHALL add retire_count at each edge, wrap modulo 2^CNT_W, and never saturate.
REQ-028 mispredict SHALL be 0 whenever retire_count=0.

Reset
REQ-029 While reset=1, at the edge: state<=RUN, halted<=0, retired_total<=0.
REQ-030 While reset=1, all combinational outputs SHALL be forced to 0 (retire_count, mispredict, enables).
REQ-031 Reset asserted in FLUSH or HALT SHALL take effect at that edge; no retirement occurs in the reset cycle.

Verification
REQ-032 N=3; all 3 slots valid and complete, dest_arch=5,6,0 -> retire_count=3; amap_we=3'b011; free_valid=3'b011; retired_total +3 next cycle.
REQ-033 Slot0 complete, slot1 incomplete, slot2 complete -> retire_count=1, slot2 held; next cycle slot1 completes -> retire_count>=2.
REQ-034 head_idx=ROB_SZ-1; slot1 is a mispredicted branch with target 0x100 -> retire_count=2, mispredict=1, mispred_idx=0, redirect_pc=0x100; next cycle retire_count=0; the cycle after, RUN.
REQ-035 Slot0 is a halt, slot1 valid and complete -> retire_count=1, next cycle halted=1; further valid heads -> retire_count=0 until reset.
REQ-036 Reset asserted during FLUSH, then during HALT -> next cycle state RUN, halted=0, retired_total=0, outputs 0 while reset=1.
REQ-037 head_valids=0 -> retire_count=0, no enables, retired_total unchanged.
